// File: rtl/dmg_vram_pkg.sv
// Shared widths, owner codes and FSM states
// for the VRAM access arbiter.
package dmg_vram_pkg;

    localparam int VRAM_AW = 13;
    localparam int VRAM_DW = 8;

    localparam logic [VRAM_DW-1:0] VRAM_OPEN_BUS = 8'hFF;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_PPU  = 2'd1,
        OWN_DMA  = 2'd2,
        OWN_CPU  = 2'd3
    } owner_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2
    } state_e;

endpackage

// File: rtl/vram_access_arbiter_if.sv
// Requester handshakes, read return path and
// VRAM pad signals of the access arbiter.
interface vram_access_arbiter_if
    import dmg_vram_pkg::*;
#(
    parameter int AW = VRAM_AW,
    parameter int DW = VRAM_DW
);

    logic          ppu_mode3;
    logic          ppu_req;
    logic [AW-1:0] ppu_addr;
    logic          ppu_ack;
    logic          dma_req;
    logic [AW-1:0] dma_addr;
    logic          dma_ack;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] rdata;
    logic          rdata_valid;
    logic [1:0]    rdata_owner;
    logic [AW-1:0] ma;
    logic [DW-1:0] md_out;
    logic          md_oe;
    logic [DW-1:0] md_in;
    logic          nmcs;
    logic          nmoe;
    logic          nmwr;

    modport slave (
        input  ppu_mode3, ppu_req, ppu_addr,
        input  dma_req, dma_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  md_in,
        output ppu_ack, dma_ack, cpu_ack,
        output rdata, rdata_valid, rdata_owner,
        output ma, md_out, md_oe,
        output nmcs, nmoe, nmwr
    );

    modport master (
        output ppu_mode3, ppu_req, ppu_addr,
        output dma_req, dma_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output md_in,
        input  ppu_ack, dma_ack, cpu_ack,
        input  rdata, rdata_valid, rdata_owner,
        input  ma, md_out, md_oe,
        input  nmcs, nmoe, nmwr
    );

endinterface

// File: rtl/vram_arb_prio.sv
// Fixed-priority picker: PPU > DMA > CPU, with
// DMA/CPU locked out during PPU mode 3.
module vram_arb_prio (
    input  logic       ppu_req,
    input  logic       dma_req,
    input  logic       cpu_req,
    input  logic       ppu_mode3,
    output logic [2:0] grant,
    output logic       cpu_blocked
);

    always_comb begin
        grant = 3'b000;
        priority case (1'b1)
            ppu_req:                grant = 3'b001;
            dma_req && !ppu_mode3:  grant = 3'b010;
            cpu_req && !ppu_mode3:  grant = 3'b100;
            default:                grant = 3'b000;
        endcase
    end

    // DMA is never eligible in mode 3, so only PPU can pre-empt
    assign cpu_blocked = cpu_req && ppu_mode3 && !ppu_req;

endmodule

// File: rtl/vram_access_arbiter.sv
// VRAM bus sequencer and requester arbiter.
// Define VRAM_ARB_STATS_EN for CPU stall/blocked counters.
module vram_access_arbiter
    import dmg_vram_pkg::*;
#(
    parameter int            AW       = VRAM_AW,
    parameter int            DW       = VRAM_DW,
    parameter logic [DW-1:0] OPEN_BUS = VRAM_OPEN_BUS
) (
    input logic clk,
    input logic nreset,
    vram_access_arbiter_if.slave bus
`ifdef VRAM_ARB_STATS_EN
    ,
    output logic [15:0] stat_cpu_stall,
    output logic [15:0] stat_cpu_blocked
`endif
);

    state_e        state;
    logic [2:0]    grant;
    logic          cpu_blocked;
    logic          eval;
    logic          take;
    logic          blk;
    logic [AW-1:0] addr_q;
    logic          we_q;
    logic [DW-1:0] wdata_q;
    owner_e        own_q;
    logic [DW-1:0] rdata_q;
    logic          rvalid_q;
    owner_e        rown_q;

    vram_arb_prio u_prio (
        .ppu_req     (bus.ppu_req),
        .dma_req     (bus.dma_req),
        .cpu_req     (bus.cpu_req),
        .ppu_mode3   (bus.ppu_mode3),
        .grant       (grant),
        .cpu_blocked (cpu_blocked)
    );

    // Grants are taken in IDLE and in the last STROBE cycle
    assign eval = (state == ST_IDLE) || (state == ST_STROBE);
    assign take = eval && (grant != 3'b000);
    assign blk  = (state == ST_IDLE) && cpu_blocked;

    assign bus.ppu_ack = nreset && take && grant[0];
    assign bus.dma_ack = nreset && take && grant[1];
    assign bus.cpu_ack = nreset && ((take && grant[2]) || blk);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state   <= ST_IDLE;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            own_q   <= OWN_NONE;
        end else begin
            unique case (state)
                ST_SETUP: state <= ST_STROBE;
                default:  state <= take ? ST_SETUP : ST_IDLE;
            endcase
            if (take) begin
                priority case (1'b1)
                    grant[0]: begin
                        addr_q <= bus.ppu_addr;
                        we_q   <= 1'b0;
                        own_q  <= OWN_PPU;
                    end
                    grant[1]: begin
                        addr_q <= bus.dma_addr;
                        we_q   <= 1'b0;
                        own_q  <= OWN_DMA;
                    end
                    default: begin
                        addr_q <= bus.cpu_addr;
                        we_q   <= bus.cpu_we;
                        own_q  <= OWN_CPU;
                        if (bus.cpu_we)
                            wdata_q <= bus.cpu_wdata;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            rdata_q  <= OPEN_BUS;
            rvalid_q <= 1'b0;
            rown_q   <= OWN_NONE;
        end else begin
            rvalid_q <= 1'b0;
            if (state == ST_STROBE && !we_q) begin
                rdata_q  <= bus.md_in;
                rvalid_q <= 1'b1;
                rown_q   <= own_q;
            end else if (blk && !bus.cpu_we) begin
                rdata_q  <= OPEN_BUS;
                rvalid_q <= 1'b1;
                rown_q   <= OWN_CPU;
            end
        end
    end

    assign bus.rdata       = rdata_q;
    assign bus.rdata_valid = rvalid_q;
    assign bus.rdata_owner = rown_q;

    assign bus.ma     = addr_q;
    assign bus.md_out = wdata_q;
    assign bus.md_oe  = (state == ST_STROBE) && we_q;
    assign bus.nmcs   = (state == ST_IDLE);
    assign bus.nmoe   = !((state == ST_STROBE) && !we_q);
    assign bus.nmwr   = !((state == ST_STROBE) && we_q);

`ifdef VRAM_ARB_STATS_EN
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stat_cpu_stall   <= '0;
            stat_cpu_blocked <= '0;
        end else begin
            if (bus.cpu_req && !bus.cpu_ack &&
                stat_cpu_stall != 16'hFFFF)
                stat_cpu_stall <= stat_cpu_stall + 16'd1;
            if (blk && stat_cpu_blocked != 16'hFFFF)
                stat_cpu_blocked <= stat_cpu_blocked + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vram_access_arbiter.sv
// Random three-requester traffic against a
// transaction-level model of the VRAM arbiter.
module tb_vram_access_arbiter;
    import dmg_vram_pkg::*;

    localparam int NCYC = 3000;
    localparam int NE   = NCYC + 8;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    vram_access_arbiter_if bus ();

`ifdef VRAM_ARB_STATS_EN
    logic [15:0] st_stall;
    logic [15:0] st_blk;
`endif

    vram_access_arbiter dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
`ifdef VRAM_ARB_STATS_EN
        ,
        .stat_cpu_stall   (st_stall),
        .stat_cpu_blocked (st_blk)
`endif
    );

    logic [7:0] mem     [8192];
    logic [7:0] ref_mem [8192];
    assign bus.md_in = mem[bus.ma];

    int n_chk  = 0;
    int n_pass = 0;
    int cur_c  = -1;

    // expected pad/return state per cycle
    bit          e_ncs  [NE];
    bit          e_noe  [NE];
    bit          e_nwr  [NE];
    bit          e_mdoe [NE];
    bit          e_val  [NE];
    bit          e_maon [NE];
    logic [12:0] e_ma   [NE];
    logic [7:0]  e_md   [NE];
    logic [7:0]  e_rd   [NE];
    logic [1:0]  e_own  [NE];

    bit gp, gd, gc, gb;
    int nxt_eval = 0;
    int last_g   = -10;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s cyc=%0d got=%0h want=%0h",
                      tag, cur_c, got, exp);
    endtask

    function automatic logic [12:0] rnd_addr();
        logic [12:0] a;
        a = 13'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) a[12:5] = '1;
        return a;
    endfunction

    task automatic stim();
        if (gp) bus.ppu_req = 1'b0;
        if (gd) bus.dma_req = 1'b0;
        if (gc || gb) bus.cpu_req = 1'b0;
        if ($urandom_range(0, 15) == 0)
            bus.ppu_mode3 = !bus.ppu_mode3;
        if (!bus.ppu_req) begin
            if ($urandom_range(0, 7) == 0) begin
                bus.ppu_req  = 1'b1;
                bus.ppu_addr = rnd_addr();
            end
        end
        if (!bus.dma_req) begin
            if ($urandom_range(0, 3) == 0) begin
                bus.dma_req  = 1'b1;
                bus.dma_addr = rnd_addr();
            end
        end else if ($urandom_range(0, 39) == 0) begin
            bus.dma_req = 1'b0;
        end
        if (!bus.cpu_req) begin
            if ($urandom_range(0, 2) == 0) begin
                bus.cpu_req   = 1'b1;
                bus.cpu_we    = 1'($urandom_range(0, 1));
                bus.cpu_addr  = rnd_addr();
                bus.cpu_wdata = 8'($urandom);
            end
        end else if ($urandom_range(0, 39) == 0) begin
            bus.cpu_req = 1'b0;
        end
    endtask

    // One access = ack, setup, strobe; reads return a cycle later
    task automatic model_step(input int c);
        bit          busy;
        bit          idle;
        bit          we;
        logic [12:0] a;
        logic [1:0]  own;
        busy = c < nxt_eval;
        idle = c >= last_g + 3;
        gp = bus.ppu_req && !busy;
        gd = !gp && bus.dma_req && !bus.ppu_mode3 && !busy;
        gc = !gp && !gd && bus.cpu_req &&
             !bus.ppu_mode3 && !busy;
        gb = !gp && bus.cpu_req && bus.ppu_mode3 && idle;
        if (gp || gd || gc) begin
            if (gp) begin
                a = bus.ppu_addr; we = 1'b0; own = OWN_PPU;
            end else if (gd) begin
                a = bus.dma_addr; we = 1'b0; own = OWN_DMA;
            end else begin
                a = bus.cpu_addr; we = bus.cpu_we; own = OWN_CPU;
            end
            e_ncs[c+1] = 1'b0; e_maon[c+1] = 1'b1; e_ma[c+1] = a;
            e_ncs[c+2] = 1'b0; e_maon[c+2] = 1'b1; e_ma[c+2] = a;
            if (we) begin
                e_nwr[c+2]  = 1'b0;
                e_mdoe[c+2] = 1'b1;
                e_md[c+2]   = bus.cpu_wdata;
                ref_mem[a]  = bus.cpu_wdata;
            end else begin
                e_noe[c+2] = 1'b0;
                e_val[c+3] = 1'b1;
                e_rd[c+3]  = ref_mem[a];
                e_own[c+3] = own;
            end
            last_g   = c;
            nxt_eval = c + 2;
        end
        if (gb && !bus.cpu_we) begin
            e_val[c+1] = 1'b1;
            e_rd[c+1]  = 8'hFF;
            e_own[c+1] = OWN_CPU;
        end
    endtask

    task automatic check_cycle(input int c);
        check("ppu_ack", bus.ppu_ack, gp);
        check("dma_ack", bus.dma_ack, gd);
        check("cpu_ack", bus.cpu_ack, gc || gb);
        check("nmcs", bus.nmcs, e_ncs[c]);
        check("nmoe", bus.nmoe, e_noe[c]);
        check("nmwr", bus.nmwr, e_nwr[c]);
        check("md_oe", bus.md_oe, e_mdoe[c]);
        check("rdata_valid", bus.rdata_valid, e_val[c]);
        if (e_maon[c]) check("ma", bus.ma, e_ma[c]);
        if (e_mdoe[c]) check("md_out", bus.md_out, e_md[c]);
        if (e_val[c]) begin
            check("rdata", bus.rdata, e_rd[c]);
            check("rdata_owner", bus.rdata_owner, e_own[c]);
        end
    endtask

    initial begin
        bit seen;
        for (int i = 0; i < 8192; i++) begin
            mem[i]     = 8'(i) ^ 8'h5A;
            ref_mem[i] = 8'(i) ^ 8'h5A;
        end
        for (int i = 0; i < NE; i++) begin
            e_ncs[i] = 1'b1; e_noe[i] = 1'b1; e_nwr[i] = 1'b1;
            e_mdoe[i] = 1'b0; e_val[i] = 1'b0; e_maon[i] = 1'b0;
        end
        bus.ppu_mode3 = 1'b0;
        bus.ppu_req   = 1'b1;
        bus.ppu_addr  = '0;
        bus.dma_req   = 1'b0;
        bus.dma_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;

        #13;
        check("rst_ppu_ack", bus.ppu_ack, 1'b0);
        check("rst_nmcs", bus.nmcs, 1'b1);
        check("rst_nmoe", bus.nmoe, 1'b1);
        check("rst_nmwr", bus.nmwr, 1'b1);
        check("rst_md_oe", bus.md_oe, 1'b0);
        check("rst_ma", bus.ma, 13'h0);
        check("rst_md_out", bus.md_out, 8'h00);
        check("rst_rdata", bus.rdata, 8'hFF);
        check("rst_valid", bus.rdata_valid, 1'b0);
        check("rst_owner", bus.rdata_owner, OWN_NONE);
        bus.ppu_req = 1'b0;
        @(posedge clk); #1;
        nreset = 1'b1;

        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk); #1;
            cur_c = c;
            stim();
            @(negedge clk);
            model_step(c);
            check_cycle(c);
            if (!bus.nmwr && !bus.nmcs) mem[bus.ma] = bus.md_out;
        end

        bus.ppu_req   = 1'b0;
        bus.dma_req   = 1'b0;
        bus.cpu_req   = 1'b0;
        bus.ppu_mode3 = 1'b0;
        repeat (6) @(posedge clk);
        cur_c = -2;

        #1;
        bus.cpu_req  = 1'b1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 13'h0005;
        @(negedge clk);
        check("rst_seq_ack", bus.cpu_ack, 1'b1);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("rst_seq_setup_cs", bus.nmcs, 1'b0);
        @(posedge clk); #2;
        check("rst_seq_strobe_oe", bus.nmoe, 1'b0);
        nreset = 1'b0;
        #1;
        check("rst_seq_cs_high", bus.nmcs, 1'b1);
        check("rst_seq_oe_high", bus.nmoe, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("rst_seq_no_valid", bus.rdata_valid, 1'b0);
        end
        #1;
        nreset = 1'b1;

`ifdef VRAM_ARB_STATS_EN
        @(posedge clk); #1;
        bus.ppu_mode3 = 1'b1;
        bus.ppu_req   = 1'b1;
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = 1'b0;
        repeat (70000) @(posedge clk);
        @(negedge clk);
        check("stat_stall_sat", st_stall, 16'hFFFF);
        check("stat_blk_zero", st_blk, 16'h0);
        @(posedge clk); #1;
        bus.ppu_req = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 8 && !seen; k++) begin
            @(negedge clk);
            seen = bus.cpu_ack;
        end
        check("stat_blk_ack_seen", seen, 1'b1);
        @(posedge clk); #1;
        bus.cpu_req = 1'b0;
        @(negedge clk);
        check("stat_blk_one", st_blk, 16'h1);
`else
        seen = 1'b0;
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
